// File: rtl/mxm_if.sv
// Element stream into the dot-product engine and the registered result back out.
interface mxm_if #(
  parameter int W = 8
);
  logic signed [W-1:0] A;
  logic signed [W-1:0] X;
  logic signed [W-1:0] Y;

  modport master (
    output A,
    output X,
    input  Y
  );

  modport slave (
    input  A,
    input  X,
    output Y
  );
endinterface

// File: rtl/mxm.sv
// Streaming signed dot-product kernel: multiply register feeding a group-of-N accumulator.
module mxm #(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic    clk,
  input  logic    rst,
  mxm_if.slave    bus
);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * W + KW;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  logic                   r_started;
  logic [KW-1:0]          r_k;
  logic signed [2*W-1:0]  r_p;
  logic                   r_last;
  logic signed [AW-1:0]   r_acc;
  logic signed [W-1:0]    r_y;

  logic signed [2*W-1:0]  w_aExt;
  logic signed [2*W-1:0]  w_xExt;
  logic signed [2*W-1:0]  w_prod;
  logic signed [AW-1:0]   w_pExt;
  logic signed [AW-1:0]   w_sum;
  logic                   w_kLast;

  assign w_aExt  = {{W{bus.A[W-1]}}, bus.A};
  assign w_xExt  = {{W{bus.X[W-1]}}, bus.X};
  assign w_prod  = w_aExt * w_xExt;
  assign w_pExt  = {{KW{r_p[2*W-1]}}, r_p};
  assign w_sum   = r_acc + w_pExt;
  assign w_kLast = (r_k == KLAST);

  // Stage 1: the first edge after reset only arms the pipeline; every edge after samples a pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_started <= 1'b0;
      r_k       <= '0;
      r_p       <= '0;
      r_last    <= 1'b0;
    end else if (!r_started) begin
      r_started <= 1'b1;
      r_p       <= '0;
      r_last    <= 1'b0;
    end else begin
      r_p    <= w_prod;
      r_last <= w_kLast;
      r_k    <= w_kLast ? '0 : r_k + 1'b1;
    end
  end

  // Stage 2: a tagged product closes the group, so the next group restarts from zero with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_y   <= '0;
    end else if (r_last) begin
      r_acc <= '0;
      r_y   <= w_sum[W-1:0];
    end else begin
      r_acc <= w_sum;
    end
  end

  assign bus.Y = r_y;
endmodule

// File: tb/tb_mxm.sv
// Directed and random checks of mxm against a cycle-level scoreboard of completed groups.
module tb_mxm;
  localparam int W = 8;
  localparam int N = 8;

  typedef struct {
    int         due;
    logic [7:0] val;
  } result_t;

  logic clk;
  logic rst;

  mxm_if #(.W(W)) bus ();

  mxm #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  result_t    sbQ[$];
  logic [7:0] expY;
  int         cycle;
  int         vectorCount;
  int         missCount;
  bit         mStarted;
  int         mK;
  int         mSum;

  task automatic checkOutput(input string tag);
    vectorCount++;
    assert (bus.Y === expY) else begin
      missCount++;
      $error("[TB] FAIL %s: cycle %0d Y=%02h expected %02h", tag, cycle, bus.Y, expY);
    end
  endtask

  task automatic checkConst(input string tag, input logic [7:0] want);
    vectorCount++;
    assert (bus.Y === want) else begin
      missCount++;
      $error("[TB] FAIL %s: cycle %0d Y=%02h expected %02h", tag, cycle, bus.Y, want);
    end
  endtask

  // One clock edge: drive the pair, advance the reference model, then compare Y after the edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] x, input string tag);
    result_t r;
    bus.A = a;
    bus.X = x;
    @(posedge clk);
    #1;
    if (rst) begin
      mStarted = 1'b0;
      mK       = 0;
      mSum     = 0;
      expY     = 8'h00;
      sbQ.delete();
    end else if (!mStarted) begin
      mStarted = 1'b1;
    end else begin
      mSum += int'($signed(a)) * int'($signed(x));
      mK++;
      if (mK == N) begin
        r.due = cycle + 1;
        r.val = mSum[7:0];
        sbQ.push_back(r);
        mSum = 0;
        mK   = 0;
      end
    end
    if (sbQ.size() > 0 && sbQ[0].due == cycle) begin
      r    = sbQ.pop_front();
      expY = r.val;
    end
    checkOutput(tag);
    cycle++;
  endtask

  task automatic applyGroup(input logic [7:0] a, input logic [7:0] x, input string tag);
    for (int i = 0; i < N; i++) applyStimulus(a, x, tag);
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    cycle       = 0;
    expY        = 8'h00;
    mStarted    = 1'b0;
    mK          = 0;
    mSum        = 0;
    rst         = 1'b1;
    bus.A       = '0;
    bus.X       = '0;

    for (int i = 0; i < 3; i++) applyStimulus(8'h7F, 8'h7F, "reset");
    checkConst("reset_y", 8'h00);

    rst   = 1'b0;
    cycle = 0;
    applyStimulus(8'h7F, 8'h7F, "dead");
    applyGroup(8'd1, 8'd1, "unit");
    checkConst("unit_before", 8'h00);

    for (int i = 0; i < N; i++) begin
      applyStimulus(8'd2, 8'd2, "unit_hold");
      checkConst("unit_y", 8'd8);
    end
    applyStimulus(8'hFF, 8'd2, "second");
    checkConst("second_y", 8'd32);

    for (int i = 1; i < N; i++) applyStimulus(8'hFF, 8'd2, "neg");
    applyStimulus(8'hFD, 8'hFC, "neg_done");
    checkConst("neg_y", 8'hF0);
    for (int i = 1; i < N; i++) applyStimulus(8'hFD, 8'hFC, "negneg");
    applyStimulus(8'd16, 8'd16, "negneg_done");
    checkConst("negneg_y", 8'h60);
    for (int i = 1; i < N; i++) applyStimulus(8'd16, 8'd16, "wrap");
    applyStimulus(8'd127, 8'd1, "wrap_done");
    checkConst("wrap_y", 8'h00);
    for (int i = 1; i < N; i++) applyStimulus(8'd127, 8'd1, "wrap2");
    applyStimulus(8'd0, 8'd0, "wrap2_done");
    checkConst("wrap2_y", 8'hF8);
    for (int i = 1; i < N; i++) applyStimulus(8'd0, 8'd0, "zero");

    for (int g = 0; g < 60; g++) begin
      for (int i = 0; i < N; i++) begin
        applyStimulus(8'($urandom), 8'($urandom), "random");
      end
    end

    for (int i = 0; i < 5; i++) applyStimulus(8'd1, 8'd1, "partial");
    rst = 1'b1;
    applyStimulus(8'd1, 8'd1, "mid_reset");
    checkConst("mid_reset_y", 8'h00);
    rst = 1'b0;
    cycle = 0;
    applyStimulus(8'd9, 8'd9, "dead2");
    applyGroup(8'd2, 8'd3, "after_reset");
    checkConst("no_partial", 8'h00);
    applyStimulus(8'd0, 8'd0, "after_reset_done");
    checkConst("after_reset_y", 8'd48);
    applyStimulus(8'd0, 8'd0, "tail");

    vectorCount++;
    assert (sbQ.size() == 0) else begin
      missCount++;
      $error("[TB] FAIL drain: %0d results pending, expected 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
